// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control block: controller states, the
// memory-class opcode and the bit positions of the instruction fields.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    localparam logic [2:0] OP_MEM = 3'b111;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 13;
    localparam int RS_MSB = 12;
    localparam int RS_LSB = 10;
    localparam int RT_MSB = 9;
    localparam int RT_LSB = 7;
    localparam int RD_MSB = 6;
    localparam int RD_LSB = 4;
    localparam int ST_BIT = 0;

endpackage

// File: rtl/cpu_ctrl.sv
// Multi-cycle instruction sequencer: fetches a word, decodes it, runs the
// optional data-memory phase and pulses the register-file write enable.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [PC_W-1:0]    pc,
    output logic               instr_req,
    input  logic               instr_ack,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [2:0]         alu_op,
    output logic [2:0]         rs_sel,
    output logic [2:0]         rt_sel,
    output logic [2:0]         rd_sel,
    output logic               reg_write,
    output logic               mem_req,
    output logic               mem_we,
    input  logic               mem_ack,
    output logic               busy
);

    state_t               r_state;
    state_t               w_nextState;
    logic [PC_W-1:0]      r_pc;
    logic [INSTR_W-1:0]   r_ir;
    logic                 w_isMem;
    logic                 w_isStore;
    logic                 w_finish;
    logic                 w_unusedIr;

    assign w_isMem    = (r_ir[OP_MSB:OP_LSB] == OP_MEM);
    assign w_isStore  = r_ir[ST_BIT];
    assign w_unusedIr = ^r_ir[RD_LSB-1:ST_BIT+1];

    // Instruction retires either after write-back or when a store is acknowledged.
    assign w_finish = (r_state == ST_WB) ||
                      ((r_state == ST_MEM) && mem_ack && w_isStore);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (w_finish) begin
            w_nextState = run ? ST_FETCH : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (run) w_nextState = ST_FETCH;
                ST_FETCH:  if (instr_ack) w_nextState = ST_DECODE;
                ST_DECODE: w_nextState = ST_EXEC;
                ST_EXEC:   w_nextState = w_isMem ? ST_MEM : ST_WB;
                ST_MEM:    if (mem_ack) w_nextState = ST_WB;
                default:   w_nextState = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        instr_req = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        reg_write = 1'b0;
        busy      = 1'b1;
        case (r_state)
            ST_IDLE:  busy      = 1'b0;
            ST_FETCH: instr_req = 1'b1;
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = w_isStore;
            end
            ST_WB:    reg_write = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (w_finish) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    // The IR only loads on an accepted fetch so the datapath selects stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir <= '0;
        end else if ((r_state == ST_FETCH) && instr_ack) begin
            r_ir <= instr_data;
        end
    end

    assign pc     = r_pc;
    assign alu_op = r_ir[OP_MSB:OP_LSB];
    assign rs_sel = r_ir[RS_MSB:RS_LSB];
    assign rt_sel = r_ir[RT_MSB:RT_LSB];
    assign rd_sel = r_ir[RD_MSB:RD_LSB];

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed self-checking bench for cpu_ctrl: arithmetic, load, store,
// run drop, reset abort and program-counter wrap.
module tb_cpu_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic [7:0]  pc;
    logic        instr_req;
    logic        instr_ack;
    logic [15:0] instr_data;
    logic [2:0]  alu_op;
    logic [2:0]  rs_sel;
    logic [2:0]  rt_sel;
    logic [2:0]  rd_sel;
    logic        reg_write;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        busy;

    int errors = 0;
    int checks = 0;

    cpu_ctrl #(.PC_W(8), .INSTR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .pc         (pc),
        .instr_req  (instr_req),
        .instr_ack  (instr_ack),
        .instr_data (instr_data),
        .alu_op     (alu_op),
        .rs_sel     (rs_sel),
        .rt_sel     (rt_sel),
        .rd_sel     (rd_sel),
        .reg_write  (reg_write),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic iAck,
                                 input logic [15:0] data, input logic mAck);
        run        = r;
        instr_ack  = iAck;
        instr_data = data;
        mem_ack    = mAck;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        tick();
        tick();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pc", pc, 0);
        checkOutput("rst_ireq", instr_req, 0);
        checkOutput("rst_mreq", mem_req, 0);
        checkOutput("rst_we", mem_we, 0);
        checkOutput("rst_regwr", reg_write, 0);
        checkOutput("rst_alu", alu_op, 0);
        rst = 1'b0;
        tick();
        checkOutput("idle_norun_busy", busy, 0);

        $display("[TB] arithmetic instruction");
        applyStimulus(1'b1, 1'b1, 16'h0260, 1'b0);
        tick();
        checkOutput("ar_fetch_ireq", instr_req, 1);
        checkOutput("ar_fetch_busy", busy, 1);
        checkOutput("ar_fetch_pc", pc, 0);
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("ar_alu", alu_op, 0);
        checkOutput("ar_rs", rs_sel, 0);
        checkOutput("ar_rt", rt_sel, 4);
        checkOutput("ar_rd", rd_sel, 6);
        checkOutput("ar_dec_ireq", instr_req, 0);
        checkOutput("ar_dec_regwr", reg_write, 0);
        tick();
        checkOutput("ar_exec_regwr", reg_write, 0);
        checkOutput("ar_exec_mreq", mem_req, 0);
        tick();
        checkOutput("ar_wb_regwr", reg_write, 1);
        checkOutput("ar_wb_pc", pc, 0);
        tick();
        checkOutput("ar_next_regwr", reg_write, 0);
        checkOutput("ar_next_ireq", instr_req, 1);
        checkOutput("ar_next_pc", pc, 1);

        $display("[TB] load with delayed mem_ack");
        applyStimulus(1'b1, 1'b1, 16'hE400, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("ld_alu", alu_op, 7);
        checkOutput("ld_rs", rs_sel, 1);
        checkOutput("ld_dec_mreq", mem_req, 0);
        tick();
        checkOutput("ld_exec_mreq", mem_req, 0);
        tick();
        checkOutput("ld_mem1_mreq", mem_req, 1);
        checkOutput("ld_mem1_we", mem_we, 0);
        checkOutput("ld_mem1_ireq", instr_req, 0);
        tick();
        checkOutput("ld_mem2_mreq", mem_req, 1);
        tick();
        checkOutput("ld_mem3_mreq", mem_req, 1);
        tick();
        checkOutput("ld_mem4_mreq", mem_req, 1);
        checkOutput("ld_mem4_regwr", reg_write, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checkOutput("ld_wb_mreq", mem_req, 0);
        checkOutput("ld_wb_regwr", reg_write, 1);
        tick();
        checkOutput("ld_next_regwr", reg_write, 0);
        checkOutput("ld_next_ireq", instr_req, 1);
        checkOutput("ld_next_pc", pc, 2);

        $display("[TB] store");
        applyStimulus(1'b1, 1'b1, 16'hE401, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("st_dec_regwr", reg_write, 0);
        tick();
        checkOutput("st_exec_regwr", reg_write, 0);
        tick();
        checkOutput("st_mem_mreq", mem_req, 1);
        checkOutput("st_mem_we", mem_we, 1);
        checkOutput("st_mem_regwr", reg_write, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checkOutput("st_next_regwr", reg_write, 0);
        checkOutput("st_next_ireq", instr_req, 1);
        checkOutput("st_next_mreq", mem_req, 0);
        checkOutput("st_next_pc", pc, 3);

        $display("[TB] run dropped during EXEC");
        applyStimulus(1'b1, 1'b1, 16'h0260, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        tick();
        run = 1'b0;
        tick();
        checkOutput("rd_wb_regwr", reg_write, 1);
        checkOutput("rd_wb_busy", busy, 1);
        tick();
        checkOutput("rd_idle_busy", busy, 0);
        checkOutput("rd_idle_ireq", instr_req, 0);
        checkOutput("rd_idle_pc", pc, 4);
        tick();
        checkOutput("rd_idle2_ireq", instr_req, 0);

        $display("[TB] reset during MEM");
        applyStimulus(1'b1, 1'b1, 16'hE400, 1'b0);
        tick();
        checkOutput("rm_fetch_pc", pc, 4);
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        tick();
        tick();
        checkOutput("rm_mem_mreq", mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rm_async_mreq", mem_req, 0);
        checkOutput("rm_async_busy", busy, 0);
        checkOutput("rm_async_pc", pc, 0);
        checkOutput("rm_async_alu", alu_op, 0);
        checkOutput("rm_async_regwr", reg_write, 0);
        mem_ack = 1'b1;
        tick();
        checkOutput("rm_held_regwr", reg_write, 0);
        rst = 1'b0;
        mem_ack = 1'b0;
        tick();
        checkOutput("rm_refetch_ireq", instr_req, 1);
        checkOutput("rm_refetch_pc", pc, 0);
        checkOutput("rm_refetch_regwr", reg_write, 0);

        $display("[TB] pc wrap");
        applyStimulus(1'b1, 1'b1, 16'h0260, 1'b0);
        for (int i = 0; i < 255; i++) begin
            repeat (4) tick();
        end
        checkOutput("wrap_pc255", pc, 255);
        checkOutput("wrap_ireq", instr_req, 1);
        repeat (4) tick();
        checkOutput("wrap_pc0", pc, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
